// File: rtl/cache_mem_pkg.sv
// Shared encodings for the cache-side memory arbiter: read FSM states and request type codes.
package cache_mem_pkg;

    typedef enum logic [2:0] {
        R_IDLE = 3'b001,
        R_REQ  = 3'b010,
        R_RESP = 3'b100
    } rd_state_e;

    localparam logic [2:0] RD_TYPE_LINE = 3'b100;
    localparam logic [2:0] WR_TYPE_LINE = 3'b100;
    localparam logic [2:0] WR_TYPE_WORD = 3'b010;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to whoever was not served last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt
);

    always_comb begin
        gnt = 1'b0;
        if (req == 2'b11) begin
            gnt = ~last;
        end else if (req[1]) begin
            gnt = 1'b1;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one rd/wr/ret memory port between icache (s0) and dcache (s1).
// Reads are serialised one line at a time via round-robin; writes use a rotating token.
module cache_mem_arbiter
    import cache_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              s0_rd_req,
    input  logic [2:0]        s0_rd_type,
    input  logic [ADDR_W-1:0] s0_rd_addr,
    output logic              s0_rd_rdy,
    output logic              s0_ret_valid,
    output logic              s0_ret_last,
    output logic [DATA_W-1:0] s0_ret_data,
    input  logic              s0_wr_req,
    input  logic [2:0]        s0_wr_type,
    input  logic [ADDR_W-1:0] s0_wr_addr,
    input  logic [3:0]        s0_wr_wstrb,
    input  logic [LINE_W-1:0] s0_wr_data,
    output logic              s0_wr_rdy,

    input  logic              s1_rd_req,
    input  logic [2:0]        s1_rd_type,
    input  logic [ADDR_W-1:0] s1_rd_addr,
    output logic              s1_rd_rdy,
    output logic              s1_ret_valid,
    output logic              s1_ret_last,
    output logic [DATA_W-1:0] s1_ret_data,
    input  logic              s1_wr_req,
    input  logic [2:0]        s1_wr_type,
    input  logic [ADDR_W-1:0] s1_wr_addr,
    input  logic [3:0]        s1_wr_wstrb,
    input  logic [LINE_W-1:0] s1_wr_data,
    output logic              s1_wr_rdy,

    output logic              m_rd_req,
    output logic [2:0]        m_rd_type,
    output logic [ADDR_W-1:0] m_rd_addr,
    input  logic              m_rd_rdy,
    input  logic              m_ret_valid,
    input  logic              m_ret_last,
    input  logic [DATA_W-1:0] m_ret_data,

    output logic              m_wr_req,
    output logic [2:0]        m_wr_type,
    output logic [ADDR_W-1:0] m_wr_addr,
    output logic [3:0]        m_wr_wstrb,
    output logic [LINE_W-1:0] m_wr_data,
    input  logic              m_wr_rdy,

    output logic              err_unexp_ret
);

    rd_state_e rd_state_q;
    logic      rd_gnt_q;
    logic      rr_last_q;
    logic      wr_owner_q;
    logic      wr_owner_d;
    logic      err_q;
    logic      arb_gnt;
    logic      in_req;
    logic      in_resp;
    logic      owner_req;
    logic      wr_ok;

    rr_arb2 u_rr_arb2 (
        .req  ({s1_rd_req, s0_rd_req}),
        .last (rr_last_q),
        .gnt  (arb_gnt)
    );

    assign in_req  = (rd_state_q == R_REQ);
    assign in_resp = (rd_state_q == R_RESP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state_q <= R_IDLE;
            rd_gnt_q   <= 1'b0;
            rr_last_q  <= 1'b1;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (s0_rd_req || s1_rd_req) begin
                        rd_gnt_q   <= arb_gnt;
                        rd_state_q <= R_REQ;
                    end
                end
                R_REQ: begin
                    if (m_rd_req && m_rd_rdy) begin
                        rd_state_q <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (m_ret_valid && m_ret_last) begin
                        rr_last_q  <= rd_gnt_q;
                        rd_state_q <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        m_rd_req  = 1'b0;
        m_rd_type = '0;
        m_rd_addr = '0;
        if (in_req) begin
            m_rd_req  = rd_gnt_q ? s1_rd_req  : s0_rd_req;
            m_rd_type = rd_gnt_q ? s1_rd_type : s0_rd_type;
            m_rd_addr = rd_gnt_q ? s1_rd_addr : s0_rd_addr;
        end
    end

    assign s0_rd_rdy    = in_req & ~rd_gnt_q & m_rd_rdy;
    assign s1_rd_rdy    = in_req &  rd_gnt_q & m_rd_rdy;

    // Beats reach only the granted requester; anything outside R_RESP is dropped.
    assign s0_ret_valid = in_resp & ~rd_gnt_q & m_ret_valid;
    assign s0_ret_last  = in_resp & ~rd_gnt_q & m_ret_last;
    assign s0_ret_data  = (in_resp && !rd_gnt_q) ? m_ret_data : '0;
    assign s1_ret_valid = in_resp &  rd_gnt_q & m_ret_valid;
    assign s1_ret_last  = in_resp &  rd_gnt_q & m_ret_last;
    assign s1_ret_data  = (in_resp && rd_gnt_q) ? m_ret_data : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (m_ret_valid && !in_resp) begin
            err_q <= 1'b1;
        end
    end

    assign err_unexp_ret = err_q;

    // Write token: reset gates the muxed path so every output is quiet during reset.
    assign wr_ok      = m_wr_rdy & ~reset;
    assign owner_req  = wr_owner_q ? s1_wr_req : s0_wr_req;
    assign s0_wr_rdy  = wr_ok & ~wr_owner_q;
    assign s1_wr_rdy  = wr_ok &  wr_owner_q;
    assign m_wr_req   = owner_req & wr_ok;
    assign m_wr_type  = reset ? '0 : (wr_owner_q ? s1_wr_type  : s0_wr_type);
    assign m_wr_addr  = reset ? '0 : (wr_owner_q ? s1_wr_addr  : s0_wr_addr);
    assign m_wr_wstrb = reset ? '0 : (wr_owner_q ? s1_wr_wstrb : s0_wr_wstrb);
    assign m_wr_data  = reset ? '0 : (wr_owner_q ? s1_wr_data  : s0_wr_data);

    assign wr_owner_d = (m_wr_req || !owner_req) ? ~wr_owner_q : wr_owner_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_owner_q <= 1'b0;
        end else begin
            wr_owner_q <= wr_owner_d;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboarded bench for cache_mem_arbiter: return beats are queued when driven and checked on delivery.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;
    import cache_mem_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         s0_rd_req, s1_rd_req;
    logic [2:0]   s0_rd_type, s1_rd_type;
    logic [31:0]  s0_rd_addr, s1_rd_addr;
    logic         s0_rd_rdy, s1_rd_rdy;
    logic         s0_ret_valid, s1_ret_valid, s0_ret_last, s1_ret_last;
    logic [31:0]  s0_ret_data, s1_ret_data;
    logic         s0_wr_req, s1_wr_req;
    logic [2:0]   s0_wr_type, s1_wr_type;
    logic [31:0]  s0_wr_addr, s1_wr_addr;
    logic [3:0]   s0_wr_wstrb, s1_wr_wstrb;
    logic [127:0] s0_wr_data, s1_wr_data;
    logic         s0_wr_rdy, s1_wr_rdy;
    logic         m_rd_req, m_rd_rdy;
    logic [2:0]   m_rd_type;
    logic [31:0]  m_rd_addr;
    logic         m_ret_valid, m_ret_last;
    logic [31:0]  m_ret_data;
    logic         m_wr_req, m_wr_rdy;
    logic [2:0]   m_wr_type;
    logic [31:0]  m_wr_addr;
    logic [3:0]   m_wr_wstrb;
    logic [127:0] m_wr_data;
    logic         err_unexp_ret;

    cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LINE_W(128)) dut (
        .clk(clk), .reset(reset),
        .s0_rd_req(s0_rd_req), .s0_rd_type(s0_rd_type), .s0_rd_addr(s0_rd_addr), .s0_rd_rdy(s0_rd_rdy),
        .s0_ret_valid(s0_ret_valid), .s0_ret_last(s0_ret_last), .s0_ret_data(s0_ret_data),
        .s0_wr_req(s0_wr_req), .s0_wr_type(s0_wr_type), .s0_wr_addr(s0_wr_addr),
        .s0_wr_wstrb(s0_wr_wstrb), .s0_wr_data(s0_wr_data), .s0_wr_rdy(s0_wr_rdy),
        .s1_rd_req(s1_rd_req), .s1_rd_type(s1_rd_type), .s1_rd_addr(s1_rd_addr), .s1_rd_rdy(s1_rd_rdy),
        .s1_ret_valid(s1_ret_valid), .s1_ret_last(s1_ret_last), .s1_ret_data(s1_ret_data),
        .s1_wr_req(s1_wr_req), .s1_wr_type(s1_wr_type), .s1_wr_addr(s1_wr_addr),
        .s1_wr_wstrb(s1_wr_wstrb), .s1_wr_data(s1_wr_data), .s1_wr_rdy(s1_wr_rdy),
        .m_rd_req(m_rd_req), .m_rd_type(m_rd_type), .m_rd_addr(m_rd_addr), .m_rd_rdy(m_rd_rdy),
        .m_ret_valid(m_ret_valid), .m_ret_last(m_ret_last), .m_ret_data(m_ret_data),
        .m_wr_req(m_wr_req), .m_wr_type(m_wr_type), .m_wr_addr(m_wr_addr),
        .m_wr_wstrb(m_wr_wstrb), .m_wr_data(m_wr_data), .m_wr_rdy(m_wr_rdy),
        .err_unexp_ret(err_unexp_ret)
    );

    always #5 clk = ~clk;

    wire [276:0] all_out = {s0_rd_rdy, s0_ret_valid, s0_ret_last, s0_ret_data,
                            s1_rd_rdy, s1_ret_valid, s1_ret_last, s1_ret_data,
                            s0_wr_rdy, s1_wr_rdy, m_rd_req, m_rd_type, m_rd_addr,
                            m_wr_req, m_wr_type, m_wr_addr, m_wr_wstrb, m_wr_data, err_unexp_ret};

    typedef struct {
        int          who;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       mon_e;
    int          mon_who;
    logic [31:0] mon_data;
    logic        mon_last;
    int          checks = 0;
    int          failures = 0;
    logic        rr_last_m;

    // Return-beat scoreboard: every delivered beat must match the oldest expected one.
    always @(negedge clk) begin
        if (reset === 1'b0 && (s0_ret_valid === 1'b1 || s1_ret_valid === 1'b1)) begin
            checks++;
            if (s0_ret_valid === 1'b1 && s1_ret_valid === 1'b1) begin
                failures++;
                $display("FAIL ret_both: s0_ret_valid=1 s1_ret_valid=1, required only one");
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL ret_unexpected: s0_ret_valid=%b s1_ret_valid=%b, required none", s0_ret_valid, s1_ret_valid);
            end else begin
                mon_e    = exp_q.pop_front();
                mon_who  = s1_ret_valid ? 1 : 0;
                mon_data = s1_ret_valid ? s1_ret_data : s0_ret_data;
                mon_last = s1_ret_valid ? s1_ret_last : s0_ret_last;
                if (mon_who != mon_e.who || mon_data !== mon_e.data || mon_last !== mon_e.last) begin
                    failures++;
                    $display("FAIL ret_beat: got s%0d data=%h last=%b, required s%0d data=%h last=%b",
                             mon_who, mon_data, mon_last, mon_e.who, mon_e.data, mon_e.last);
                end
            end
        end
    end

    task automatic clear_inputs();
        s0_rd_req = 0; s0_rd_type = RD_TYPE_LINE; s0_rd_addr = '0;
        s1_rd_req = 0; s1_rd_type = RD_TYPE_LINE; s1_rd_addr = '0;
        s0_wr_req = 0; s0_wr_type = '0; s0_wr_addr = '0; s0_wr_wstrb = '0; s0_wr_data = '0;
        s1_wr_req = 0; s1_wr_type = '0; s1_wr_addr = '0; s1_wr_wstrb = '0; s1_wr_data = '0;
        m_rd_rdy = 0; m_ret_valid = 0; m_ret_last = 0; m_ret_data = '0; m_wr_rdy = 0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        rr_last_m = 1'b1;
    endtask

    task automatic start_rd(input int k, input logic [31:0] addr);
        if (k == 0) begin s0_rd_req = 1; s0_rd_addr = addr; end
        else begin s1_rd_req = 1; s1_rd_addr = addr; end
    endtask

    // Downstream responder for one line read; called at posedge+1, returns at posedge+1.
    task automatic do_read(input int k, output int lat);
        logic        seen;
        logic [31:0] addr;
        logic [31:0] d;
        seen = 0;
        lat = -1;
        addr = (k == 0) ? s0_rd_addr : s1_rd_addr;
        m_rd_rdy = 1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (m_rd_req === 1'b1) begin seen = 1; lat = n; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL rd_handshake s%0d: m_rd_req stayed 0, required 1", k);
            if (k == 0) s0_rd_req = 0; else s1_rd_req = 0;
        end else begin
            checks++;
            if ({m_rd_addr, m_rd_type, s1_rd_rdy, s0_rd_rdy} !== {addr, RD_TYPE_LINE, (k == 1), (k == 0)}) begin
                failures++;
                $display("FAIL rd_grant s%0d: addr=%h type=%b rdy1=%b rdy0=%b, required addr=%h type=%b rdy for s%0d only",
                         k, m_rd_addr, m_rd_type, s1_rd_rdy, s0_rd_rdy, addr, RD_TYPE_LINE, k);
            end
            @(posedge clk); #1;
            if (k == 0) s0_rd_req = 0; else s1_rd_req = 0;
            for (int i = 0; i < 4; i++) begin
                d = {addr[15:0], 16'h0} | ((i + 1) * 32'h11);
                m_ret_valid = 1; m_ret_data = d; m_ret_last = (i == 3);
                exp_q.push_back('{k, d, (i == 3)});
                @(posedge clk); #1;
            end
            m_ret_valid = 0; m_ret_last = 0; m_ret_data = '0;
            rr_last_m = k[0];
        end
    endtask

    task automatic do_write(input int k, input logic [31:0] addr, input logic [127:0] data, output int lat);
        logic seen;
        seen = 0;
        lat = -1;
        m_wr_rdy = 1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (((k == 0) ? s0_wr_rdy : s1_wr_rdy) === 1'b1) begin seen = 1; lat = n; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL wr_token_wait s%0d: wr_rdy stayed 0, required 1", k);
        end else begin
            if (k == 0) begin
                s0_wr_req = 1; s0_wr_type = WR_TYPE_LINE; s0_wr_addr = addr; s0_wr_data = data;
            end else begin
                s1_wr_req = 1; s1_wr_type = WR_TYPE_LINE; s1_wr_addr = addr; s1_wr_data = data;
            end
            #1;
            checks++;
            if ({m_wr_req, m_wr_type, m_wr_addr, m_wr_data} !== {1'b1, WR_TYPE_LINE, addr, data}) begin
                failures++;
                $display("FAIL wr_issue s%0d: req=%b type=%b addr=%h data=%h, required req=1 addr=%h data=%h",
                         k, m_wr_req, m_wr_type, m_wr_addr, m_wr_data, addr, data);
            end
            @(posedge clk); #1;
            if (k == 0) s0_wr_req = 0; else s1_wr_req = 0;
            @(negedge clk);
            checks++;
            if ({m_wr_req, s0_wr_rdy, s1_wr_rdy} !== {1'b0, (k == 1), (k == 0)}) begin
                failures++;
                $display("FAIL wr_toggle s%0d: m_wr_req=%b rdy0=%b rdy1=%b, required 0 %b %b",
                         k, m_wr_req, s0_wr_rdy, s1_wr_rdy, (k == 1), (k == 0));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        #2;
        reset = 1'b1;
        s0_rd_req = 1; s1_wr_data = {4{32'hdeadbeef}}; s0_wr_addr = 32'h1234;
        m_wr_rdy = 1; m_rd_rdy = 1; m_ret_valid = 1; m_ret_data = 32'h55;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL reset_outputs: outputs=%h, required all 0", all_out);
        end
        apply_reset();
        m_wr_rdy = 1;
        @(negedge clk);
        checks++;
        if ({err_unexp_ret, s0_wr_rdy, s1_wr_rdy, m_rd_req} !== 4'b0100) begin
            failures++;
            $display("FAIL reset_release: err=%b rdy0=%b rdy1=%b m_rd_req=%b, required 0 1 0 0",
                     err_unexp_ret, s0_wr_rdy, s1_wr_rdy, m_rd_req);
        end
        @(posedge clk); #1;
        m_wr_rdy = 0;
    endtask

    task automatic test_single_read();
        int lat;
        start_rd(0, 32'h1c000000);
        do_read(0, lat);
        checks++;
        if (lat != 1) begin
            failures++;
            $display("FAIL rd_latency: m_rd_req rose after %0d cycles, required 1", lat);
        end
    endtask

    task automatic test_round_robin();
        int lat;
        int first;
        apply_reset();
        start_rd(0, 32'h00000100);
        start_rd(1, 32'h00000200);
        first = rr_last_m ? 0 : 1;
        do_read(first, lat);
        do_read(1 - first, lat);
        start_rd(0, 32'h00000300);
        do_read(0, lat);
        start_rd(0, 32'h00000400);
        start_rd(1, 32'h00000500);
        first = rr_last_m ? 0 : 1;
        do_read(first, lat);
        do_read(1 - first, lat);
    endtask

    task automatic test_read_write_overlap();
        int lat_r, lat_w;
        start_rd(0, 32'h00000600);
        fork
            do_read(0, lat_r);
            begin
                repeat (3) @(posedge clk);
                #1;
                do_write(1, 32'h00001230, 128'h0f0e0d0c_0b0a0908_07060504_03020100, lat_w);
            end
        join
        m_wr_rdy = 0;
        checks++;
        if (err_unexp_ret !== 1'b0) begin
            failures++;
            $display("FAIL overlap_err: err_unexp_ret=%b, required 0", err_unexp_ret);
        end
    endtask

    task automatic test_write_token();
        int lat;
        apply_reset();
        do_write(1, 32'h00002000, 128'h11112222_33334444_55556666_77778888, lat);
        checks++;
        if (lat < 1 || lat > 2) begin
            failures++;
            $display("FAIL wr_token_latency: s1_wr_rdy after %0d cycles, required 1..2", lat);
        end
        m_wr_rdy = 0;
    endtask

    task automatic test_unexpected_ret();
        checks++;
        if (err_unexp_ret !== 1'b0) begin
            failures++;
            $display("FAIL err_before: err_unexp_ret=%b, required 0", err_unexp_ret);
        end
        m_ret_valid = 1; m_ret_last = 1; m_ret_data = 32'h99;
        @(negedge clk);
        checks++;
        if ({s0_ret_valid, s1_ret_valid} !== 2'b00) begin
            failures++;
            $display("FAIL err_routed: s0_ret_valid=%b s1_ret_valid=%b, required 0 0", s0_ret_valid, s1_ret_valid);
        end
        @(posedge clk); #1;
        m_ret_valid = 0; m_ret_last = 0; m_ret_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (err_unexp_ret !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky: err_unexp_ret=%b, required 1", err_unexp_ret);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_read();
        logic        seen;
        logic [31:0] d;
        int          lat;
        seen = 0;
        start_rd(0, 32'h00000700);
        m_rd_rdy = 1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (m_rd_req === 1'b1) begin seen = 1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL mid_handshake: m_rd_req stayed 0, required 1");
        end
        @(posedge clk); #1;
        s0_rd_req = 0;
        for (int i = 0; i < 2; i++) begin
            d = 32'h07000000 | ((i + 1) * 32'h11);
            m_ret_valid = 1; m_ret_data = d; m_ret_last = 0;
            exp_q.push_back('{0, d, 1'b0});
            @(posedge clk); #1;
        end
        m_ret_valid = 1; m_ret_data = 32'h07000033;
        #1;
        reset = 1'b1;
        s0_wr_addr = 32'habcd0000; s0_wr_data = {4{32'hcafef00d}}; s0_wr_type = WR_TYPE_WORD; s0_wr_wstrb = 4'hf;
        m_wr_rdy = 1;
        #1;
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs: outputs=%h, required all 0", all_out);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        rr_last_m = 1'b1;
        @(posedge clk); #1;
        m_ret_valid = 0; m_ret_data = '0;
        s0_wr_addr = '0; s0_wr_data = '0; s0_wr_type = '0; s0_wr_wstrb = '0; m_wr_rdy = 0;
        @(negedge clk);
        checks++;
        if (err_unexp_ret !== 1'b1) begin
            failures++;
            $display("FAIL stale_beat_err: err_unexp_ret=%b, required 1", err_unexp_ret);
        end
        @(posedge clk); #1;
        start_rd(1, 32'h00000800);
        do_read(1, lat);
        checks++;
        if (lat != 1) begin
            failures++;
            $display("FAIL post_reset_read: m_rd_req rose after %0d cycles, required 1", lat);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_read_write_overlap();
        test_write_token();
        test_unexpected_ret();
        test_reset_mid_read();
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL beats_pending: %0d expected beats never delivered, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
